op_dispatcher: RTL

Sequencing stage between the op source (parser/FIFO) and the motion handlers. It accepts one `Op_st` at a time over a valid/ready handshake and decodes `cmd`. It then either triggers the matching handler (linear, circular or servo) and waits for it to finish, or, for positioning-mode commands, holds the op stable long enough for `PositionKeeper` to sample it. It owns the shared `op` bus and all handler trigger lines.

---
 rtl/op_dispatcher_pkg.sv | 43 ++++
 rtl/op_dispatcher_decoder.sv | 22 ++
 rtl/op_dispatcher.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/op_dispatcher_pkg.sv
// Shared types for the op dispatch stage: op layout, command codes,
// dispatcher states and handler-class selection.
package op_dispatcher_pkg;

  typedef logic [7:0] cmd_t;

  localparam cmd_t CMD_G00 = 8'd0;
  localparam cmd_t CMD_G01 = 8'd1;
  localparam cmd_t CMD_G02 = 8'd2;
  localparam cmd_t CMD_G03 = 8'd3;
  localparam cmd_t CMD_G90 = 8'd90;
  localparam cmd_t CMD_G91 = 8'd91;
  localparam cmd_t CMD_M03 = 8'd131;
  localparam cmd_t CMD_M05 = 8'd133;

  typedef struct packed {
    cmd_t        cmd;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [15:0] f;
  } Op_st;

  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT_DONE, HOLD} DispatchState_e;

  typedef enum logic [2:0] {SEL_LIN, SEL_CIRC, SEL_SERVO, SEL_MODE, SEL_BAD} HandlerSel_e;

  // True for classes that are started via a trigger line.
  function automatic logic is_handler(HandlerSel_e s);
    return (s == SEL_LIN) || (s == SEL_CIRC) || (s == SEL_SERVO);
  endfunction

  // Trigger vector {servo, circ, lin} for a selection; zero for non-handlers.
  function automatic logic [2:0] trig_mask(HandlerSel_e s);
    case (s)
      SEL_LIN:   return 3'b001;
      SEL_CIRC:  return 3'b010;
      SEL_SERVO: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/op_dispatcher_decoder.sv
// Combinational cmd -> handler class mapping; kept standalone so a
// lookahead stage can decode ahead of the dispatcher.
module OpCmdDecoder
  import op_dispatcher_pkg::*;
(
  input  cmd_t        cmd_i,
  output HandlerSel_e sel_o
);

  // Map each recognised command to its handler class, everything else is BAD.
  always_comb begin
    sel_o = SEL_BAD;
    case (cmd_i)
      CMD_G00, CMD_G01: sel_o = SEL_LIN;
      CMD_G02, CMD_G03: sel_o = SEL_CIRC;
      CMD_M03, CMD_M05: sel_o = SEL_SERVO;
      CMD_G90, CMD_G91: sel_o = SEL_MODE;
      default:          sel_o = SEL_BAD;
    endcase
  end

endmodule

// File: rtl/op_dispatcher.sv
// Op dispatcher: accepts one op, triggers the matching motion handler and
// waits for completion, or holds a positioning-mode op for a fixed time.
module op_dispatcher
  import op_dispatcher_pkg::*;
#(
  parameter int unsigned MODE_HOLD_CYCLES = 4,
  parameter int unsigned ACCEPT_TIMEOUT   = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  Op_st op_in,
  input  logic op_valid,
  output logic op_ready,
  output Op_st op,
  output logic lin_trigger,
  output logic circ_trigger,
  output logic servo_trigger,
  input  logic lin_rdy,
  input  logic circ_rdy,
  input  logic servo_rdy,
  output logic busy,
  output logic err,
  input  logic err_clr
);

  localparam int HW = $clog2(MODE_HOLD_CYCLES + 1);
  localparam int TW = $clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(MODE_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(ACCEPT_TIMEOUT);

  DispatchState_e state_q, state_d;
  Op_st           op_q, op_d;
  HandlerSel_e    sel_q, sel_d;
  HandlerSel_e    in_sel;
  logic [2:0]     trig_q, trig_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [TW-1:0]  to_q, to_d;
  logic [TW-1:0]  to_inc;
  logic           err_q, err_d;
  logic           err_set;
  logic           sel_rdy;

  OpCmdDecoder u_dec (
    .cmd_i (op_in.cmd),
    .sel_o (in_sel)
  );

  assign to_inc = to_q + 1'b1;

  // Ready line of the handler the current op was sent to.
  always_comb begin
    sel_rdy = 1'b1;
    case (sel_q)
      SEL_LIN:   sel_rdy = lin_rdy;
      SEL_CIRC:  sel_rdy = circ_rdy;
      SEL_SERVO: sel_rdy = servo_rdy;
      default:   sel_rdy = 1'b1;
    endcase
  end

  // State, op, triggers, counters and error flag; everything gated by clk_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      sel_q   <= SEL_LIN;
      trig_q  <= '0;
      hold_q  <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      trig_q  <= trig_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; triggers are computed here so they are registered.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    trig_d  = trig_q;
    hold_d  = hold_q;
    to_d    = to_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (is_handler(in_sel)) begin
            op_d    = op_in;
            sel_d   = in_sel;
            trig_d  = trig_mask(in_sel);
            to_d    = '0;
            state_d = DISPATCH;
          end else if (in_sel == SEL_MODE) begin
            op_d    = op_in;
            sel_d   = SEL_MODE;
            hold_d  = HOLD_LOAD;
            state_d = HOLD;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      DISPATCH: begin
        // Acceptance wins over a timeout landing on the same cycle.
        if (!sel_rdy) begin
          trig_d  = '0;
          to_d    = '0;
          state_d = WAIT_DONE;
        end else if (to_inc == TO_LIMIT) begin
          trig_d  = '0;
          to_d    = '0;
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_inc;
        end
      end
      WAIT_DONE: begin
        if (sel_rdy) state_d = IDLE;
      end
      HOLD: begin
        if (hold_q == '0) state_d = IDLE;
        else              hold_d  = hold_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // Outputs: ready/busy decode the state, the rest come straight from registers.
  always_comb begin
    op_ready      = (state_q == IDLE);
    busy          = (state_q != IDLE);
    op            = op_q;
    lin_trigger   = trig_q[0];
    circ_trigger  = trig_q[1];
    servo_trigger = trig_q[2];
    err           = err_q;
  end

endmodule
